// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit-over-16-bit SRAM data-memory controller.
// Also holds the offset helper that maps a pipeline byte address to the SRAM byte offset.
package sram_controller_pkg;

    localparam int REGISTER_LEN  = 32;
    localparam int SRAM_DATA_LEN = 16;
    localparam int SRAM_ADDR_LEN = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    // Unsigned subtraction; wraps modulo 2^32 for addresses below the base.
    function automatic logic [REGISTER_LEN-1:0] sram_offset(
        input logic [REGISTER_LEN-1:0] address,
        input logic [REGISTER_LEN-1:0] base
    );
        return address - base;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side request/response bus of the SRAM controller.
// The pipeline is the master, the controller the slave.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic                    wr_en;
    logic                    rd_en;
    logic [REGISTER_LEN-1:0] address;
    logic [REGISTER_LEN-1:0] write_data;
    logic [REGISTER_LEN-1:0] read_data;
    logic                    ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Serves 32-bit loads/stores as two sequential 16-bit accesses (low half, then high half)
// to an asynchronous SRAM; ready stays low while an access is in flight.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [REGISTER_LEN-1:0] BASE_ADDR   = 32'd1024,
    parameter int                      SRAM_ADDR_W = 18,
    parameter int                      WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    sram_controller_if.slave         mem,
    output logic [SRAM_ADDR_W-1:0]   SRAM_ADDR,
    inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_OE_N,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N
);

    localparam int         WORD_W   = SRAM_ADDR_W - 1;
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    sram_state_e               state_r;
    sram_state_e               state_s;
    logic [3:0]                cnt_r;
    logic [3:0]                cnt_s;
    logic                      op_wr_r;
    logic [WORD_W-1:0]         word_r;
    logic [REGISTER_LEN-1:0]   wdata_r;

    logic [SRAM_ADDR_W-1:0]    sram_addr_r;
    logic [SRAM_ADDR_W-1:0]    sram_addr_s;
    logic                      we_n_r;
    logic                      we_n_s;
    logic                      dq_oe_r;
    logic                      dq_oe_s;
    logic [SRAM_DATA_LEN-1:0]  dq_out_r;
    logic [SRAM_DATA_LEN-1:0]  dq_out_s;
    logic [REGISTER_LEN-1:0]   read_data_r;

    logic                      req_s;
    logic                      accept_s;
    logic                      phase_end_s;
    logic                      cap_lo_s;
    logic                      cap_hi_s;
    logic [REGISTER_LEN-1:0]   offset_s;
    logic                      eff_wr_s;
    logic [WORD_W-1:0]         eff_word_s;
    logic [REGISTER_LEN-1:0]   eff_wdata_s;

    assign req_s       = mem.wr_en | mem.rd_en;
    assign accept_s    = (state_r == ST_IDLE) & req_s;
    assign phase_end_s = (cnt_r == LAST_CNT);
    assign offset_s    = sram_offset(mem.address, BASE_ADDR);
    assign cap_lo_s    = (state_r == ST_LOW)  & ~op_wr_r & phase_end_s;
    assign cap_hi_s    = (state_r == ST_HIGH) & ~op_wr_r & phase_end_s;

    // Next-state and phase counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 4'd0;
                if (req_s) begin
                    state_s = ST_LOW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (phase_end_s) begin
                    state_s = ST_HIGH;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            ST_HIGH: begin
                if (phase_end_s) begin
                    state_s = ST_DONE;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r + 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Pin values for the coming cycle; in IDLE the live request is what gets latched.
    always_comb begin
        if (state_r == ST_IDLE) begin
            eff_wr_s    = mem.wr_en;
            eff_word_s  = WORD_W'(offset_s >> 2);
            eff_wdata_s = mem.write_data;
        end else begin
            eff_wr_s    = op_wr_r;
            eff_word_s  = word_r;
            eff_wdata_s = wdata_r;
        end
        sram_addr_s = sram_addr_r;
        we_n_s      = 1'b1;
        dq_oe_s     = 1'b0;
        dq_out_s    = 16'h0000;
        case (state_s)
            ST_LOW: begin
                sram_addr_s = {eff_word_s, 1'b0};
                we_n_s      = ~eff_wr_s;
                dq_oe_s     = eff_wr_s;
                dq_out_s    = eff_wdata_s[15:0];
            end
            ST_HIGH: begin
                sram_addr_s = {eff_word_s, 1'b1};
                we_n_s      = ~eff_wr_s;
                dq_oe_s     = eff_wr_s;
                dq_out_s    = eff_wdata_s[31:16];
            end
            default: begin
                sram_addr_s = sram_addr_r;
                we_n_s      = 1'b1;
                dq_oe_s     = 1'b0;
                dq_out_s    = 16'h0000;
            end
        endcase
    end

    // State, latched request, registered SRAM pins and load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            op_wr_r     <= 1'b0;
            word_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            sram_addr_r <= '0;
            we_n_r      <= 1'b1;
            dq_oe_r     <= 1'b0;
            dq_out_r    <= 16'h0000;
            read_data_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            sram_addr_r <= sram_addr_s;
            we_n_r      <= we_n_s;
            dq_oe_r     <= dq_oe_s;
            dq_out_r    <= dq_out_s;
            if (accept_s) begin
                op_wr_r <= eff_wr_s;
                word_r  <= eff_word_s;
                wdata_r <= eff_wdata_s;
            end
            if (cap_lo_s) begin
                read_data_r[15:0] <= SRAM_DQ;
            end
            if (cap_hi_s) begin
                read_data_r[31:16] <= SRAM_DQ;
            end
        end
    end

    assign SRAM_DQ       = dq_oe_r ? dq_out_r : 16'bz;
    assign SRAM_ADDR     = sram_addr_r;
    assign SRAM_WE_N     = we_n_r;
    assign SRAM_CE_N     = 1'b0;
    assign SRAM_OE_N     = 1'b0;
    assign SRAM_UB_N     = 1'b0;
    assign SRAM_LB_N     = 1'b0;
    assign mem.read_data = read_data_r;
    // Combinational so the pipeline freezes in the very cycle a request shows up.
    assign mem.ready     = ((state_r == ST_IDLE) & ~req_s) | (state_r == ST_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit asynchronous SRAM
// and a halfword-level reference model checked every cycle.
module tb_sram_controller;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    sram_controller_if bus();
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

    sram_controller #(.BASE_ADDR(BASE), .SRAM_ADDR_W(18), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem(bus),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_WE_N(sram_we_n),
        .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n),
        .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: drives the bus whenever not being written (CE/OE tied active).
    logic [15:0] sram_mem [0:262143];
    assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 16'bz;
    always @(negedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;

    // Reference model: halfword contents plus expected pin values for the current cycle.
    logic [15:0] ref_hw [int];
    logic        exp_ready, exp_we_n, rd_skip, chk_en;
    logic [17:0] exp_addr, seen_lo, seen_hi;
    logic [15:0] exp_dq;
    logic [31:0] exp_rdata;
    int          cur_k, low_run, last_run;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [15:0] ref_get(input int a);
        return ref_hw.exists(a) ? ref_hw[a] : 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(bus.ready), 32'(exp_ready));
            chk("we_n", 32'(sram_we_n), 32'(exp_we_n));
            chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
            chk("dq", 32'(sram_dq), 32'(exp_dq));
            if (!rd_skip) chk("read_data", bus.read_data, exp_rdata);
            if (cur_k == 1) seen_lo = sram_addr;
            if (cur_k == W + 1) seen_hi = sram_addr;
            if (bus.ready) begin
                last_run = low_run;
                low_run  = 0;
            end else begin
                low_run++;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.wr_en = 1'b0; bus.rd_en = 1'b0;
            exp_ready = 1'b1; exp_we_n = 1'b1; rd_skip = 1'b0; cur_k = -1;
            exp_dq = ref_get(int'(exp_addr));
            @(posedge clk); #1;
        end
    endtask

    // One access: cycle 0 request in IDLE, W low-half cycles, W high-half cycles, DONE.
    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input int abort_k);
        logic [31:0] off;
        int lo, hi;
        off = a - BASE;
        lo  = int'({off[18:2], 1'b0});
        hi  = int'({off[18:2], 1'b1});
        for (int k = 0; k <= 2 * W + 1; k++) begin
            if (k == abort_k) begin
                rst = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
                exp_ready = 1'b1; exp_we_n = 1'b1; exp_addr = 18'd0;
                exp_dq = ref_get(0); exp_rdata = 32'h0; rd_skip = 1'b0; cur_k = -1;
                @(negedge clk);
                chk("rst_we_n", 32'(sram_we_n), 32'h1);
                chk("rst_read_data", bus.read_data, 32'h0);
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            bus.wr_en = wr; bus.rd_en = rd; bus.address = a; bus.write_data = d;
            cur_k = k;
            exp_ready = (k == 2 * W + 1);
            rd_skip = !wr && k > W && k <= 2 * W;
            if (k >= 1 && k <= W) begin
                exp_addr = 18'(lo); exp_we_n = !wr;
                exp_dq = wr ? d[15:0] : ref_get(lo);
            end else if (k > W && k <= 2 * W) begin
                exp_addr = 18'(hi); exp_we_n = !wr;
                exp_dq = wr ? d[31:16] : ref_get(hi);
            end else begin
                exp_we_n = 1'b1;
                exp_dq = ref_get(int'(exp_addr));
            end
            if (k == 2 * W + 1 && !wr) exp_rdata = {ref_get(hi), ref_get(lo)};
            @(posedge clk); #1;
            if (wr && k == W) ref_hw[lo] = d[15:0];
            if (wr && k == 2 * W) ref_hw[hi] = d[31:16];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0000;
        sram_mem[12] = 16'h1111;      ref_hw[12] = 16'h1111;
        sram_mem[13] = 16'h2222;      ref_hw[13] = 16'h2222;
        sram_mem[18'h3FE00] = 16'h5555; ref_hw[32'h3FE00] = 16'h5555;
        sram_mem[18'h3FE01] = 16'hAAAA; ref_hw[32'h3FE01] = 16'hAAAA;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        bus.address = 32'h0; bus.write_data = 32'h0;
        exp_ready = 1'b1; exp_we_n = 1'b1; exp_addr = 18'd0; exp_dq = 16'h0000;
        exp_rdata = 32'h0; rd_skip = 1'b0; cur_k = -1; low_run = 0; last_run = 0;
        seen_lo = 18'd0; seen_hi = 18'd0;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_read_data", bus.read_data, 32'h0);
        chk("reset_addr", 32'(sram_addr), 32'h0);
        rst = 1'b0;
        idle(2);

        access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, -1);
        chk("store_ready_low", 32'(last_run), 32'd5);
        chk("store_lo_addr", 32'(seen_lo), 32'd2);
        chk("store_hi_addr", 32'(seen_hi), 32'd3);
        idle(1);
        access(1'b0, 1'b1, 32'd1028, 32'h0, -1);
        chk("load_data", bus.read_data, 32'hDEADBEEF);
        idle(1);

        access(1'b1, 1'b0, 32'd1032, 32'h12345678, -1);
        access(1'b0, 1'b1, 32'd1032, 32'h0, -1);
        chk("b2b_ready_low", 32'(last_run), 32'd5);
        chk("b2b_load_data", bus.read_data, 32'h12345678);
        idle(1);

        access(1'b0, 1'b1, 32'd1031, 32'h0, -1);
        chk("misaligned_lo_addr", 32'(seen_lo), 32'd2);
        chk("misaligned_data", bus.read_data, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'd0, 32'h0, -1);
        chk("wrap_lo_addr", 32'(seen_lo), 32'h3FE00);
        chk("wrap_hi_addr", 32'(seen_hi), 32'h3FE01);
        chk("wrap_data", bus.read_data, 32'hAAAA5555);
        idle(1);

        access(1'b1, 1'b1, 32'd1040, 32'h0BADF00D, -1);
        chk("both_keeps_read_data", bus.read_data, 32'hAAAA5555);
        access(1'b0, 1'b1, 32'd1040, 32'h0, -1);
        chk("both_wrote", bus.read_data, 32'h0BADF00D);
        idle(1);

        access(1'b1, 1'b0, 32'd1048, 32'hCAFEF00D, W + 1);
        idle(2);
        access(1'b0, 1'b1, 32'd1048, 32'h0, -1);
        chk("partial_write", bus.read_data, 32'h2222F00D);
        idle(2);

        chk("tied_pins", {28'h0, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}, 32'h0);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
